// File: rtl/exec_pkg.sv
// Shared definitions for the execute unit: default widths, opcode encodings
// and the control state enumeration.
package exec_pkg;

  localparam int DATA_W = 5;
  localparam int REG_AW = 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } exec_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU. MUL is produced by the sequential
// multiplier in execute_unit, so here it yields zero without flagging illegal.
module alu_core #(
  parameter int DATA_W = exec_pkg::DATA_W
) (
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] alu_result,
  output logic              alu_overflow,
  output logic              alu_illegal
);
  import exec_pkg::*;

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [2:0]        shamt;

  always_comb begin
    sum          = operand_a + operand_b;
    diff         = operand_a - operand_b;
    shamt        = operand_b[2:0];
    alu_result   = '0;
    alu_overflow = 1'b0;
    alu_illegal  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_result   = sum;
        alu_overflow = (operand_a[MSB] == operand_b[MSB]) && (sum[MSB] != operand_a[MSB]);
      end
      OP_SUB: begin
        alu_result   = diff;
        alu_overflow = (operand_a[MSB] != operand_b[MSB]) && (diff[MSB] != operand_a[MSB]);
      end
      OP_AND: alu_result = operand_a & operand_b;
      OP_OR:  alu_result = operand_a | operand_b;
      OP_SLT: alu_result = DATA_W'($signed(operand_a) < $signed(operand_b));
      OP_SRL: begin
        // Shift amounts past the word width drain every bit out.
        if (int'(shamt) >= DATA_W) alu_result = '0;
        else                       alu_result = operand_a >> shamt;
      end
      OP_MUL: alu_result = '0;
      default: alu_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_unit.sv
// Multi-cycle execute stage: latches an operation on start, runs it through
// the ALU (one cycle) or a shift-add multiplier, then issues one writeback.
module execute_unit #(
  parameter int DATA_W = exec_pkg::DATA_W,
  parameter int REG_AW = exec_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [REG_AW-1:0] dest_reg,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              overflow,
  output logic              illegal,
  output logic              reg_write,
  output logic [REG_AW-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  output logic [1:0]        dbg_state
);
  import exec_pkg::*;

  // Handshake: start is a request accepted only while busy is low; done is
  // a single-cycle completion strobe coinciding with the register-file write.

  localparam int CNT_W = $clog2(DATA_W + 1);

  exec_state_e       state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              ill_q, ill_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_overflow;
  logic              alu_illegal;
  logic [DATA_W-1:0] b_shr;
  logic [DATA_W-1:0] partial;

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .alu_op      (op_q),
    .operand_a   (a_q),
    .operand_b   (b_q),
    .alu_result  (alu_result),
    .alu_overflow(alu_overflow),
    .alu_illegal (alu_illegal)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    dest_d   = dest_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    // Partial product for multiplier bit cnt_q; only low DATA_W bits matter.
    b_shr    = b_q >> cnt_q;
    partial  = b_shr[0] ? (a_q << cnt_q) : '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = operand_a;
          b_d     = operand_b;
          op_d    = alu_op;
          dest_d  = dest_reg;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = (alu_op == OP_MUL) ? ST_MUL : ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = alu_result;
        zero_d   = (alu_result == '0);
        ovf_d    = alu_overflow;
        ill_d    = alu_illegal;
        state_d  = ST_WB;
      end
      ST_MUL: begin
        // DATA_W accumulate cycles, then one cycle to commit the product.
        if (cnt_q == CNT_W'(DATA_W)) begin
          result_d = acc_q;
          zero_d   = (acc_q == '0);
          ovf_d    = 1'b0;
          ill_d    = 1'b0;
          state_d  = ST_WB;
        end else begin
          acc_d = acc_q + partial;
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      dest_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_WB);
  assign reg_write      = (state_q == ST_WB) && !ill_q;
  assign write_register = dest_q;
  assign write_data     = result_q;
  assign result         = result_q;
  assign zero           = zero_q;
  assign overflow       = ovf_q;
  assign illegal        = ill_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_execute_unit.sv
// Directed plus randomized checks of execute_unit against an arithmetic
// reference model of the operation set, latency and writeback behaviour.
module tb_execute_unit;
  localparam int DW = 5;
  localparam int AW = 1;
  localparam int MOD = 1 << DW;
  localparam int HALF = 1 << (DW - 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    alu_op;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic [AW-1:0] dest_reg;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          zero;
  logic          overflow;
  logic          illegal;
  logic          reg_write;
  logic [AW-1:0] write_register;
  logic [DW-1:0] write_data;
  logic [1:0]    dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int last_result = 0;

  execute_unit #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_op(alu_op),
    .operand_a(operand_a), .operand_b(operand_b), .dest_reg(dest_reg),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .overflow(overflow), .illegal(illegal), .reg_write(reg_write),
    .write_register(write_register), .write_data(write_data),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= HALF) ? v - MOD : v;
  endfunction

  // Reference: result, overflow and illegal from the opcode rules.
  task automatic ref_model(input int op, input int a, input int b,
                           output int res, output int ovf, output int ill);
    int s;
    res = 0; ovf = 0; ill = 0;
    case (op)
      0: begin s = sx(a) + sx(b); res = (a + b) % MOD; ovf = (s >= HALF || s < -HALF) ? 1 : 0; end
      1: begin s = sx(a) - sx(b); res = (a - b + MOD) % MOD; ovf = (s >= HALF || s < -HALF) ? 1 : 0; end
      2: res = a & b;
      3: res = a | b;
      4: res = (sx(a) < sx(b)) ? 1 : 0;
      5: res = (a * b) % MOD;
      6: res = ((b % 8) >= DW) ? 0 : (a >> (b % 8));
      default: ill = 1;
    endcase
  endtask

  // One transaction: start, optional start pulse while busy, latency and writeback checks.
  task automatic run_op(input int op, input int a, input int b, input int dest, input bit poke);
    int res, ovf, ill, lat, seen;
    ref_model(op, a, b, res, ovf, ill);
    lat = (op == 5) ? DW + 2 : 2;
    @(negedge clk);
    start = 1'b1; alu_op = 3'(op); operand_a = DW'(a); operand_b = DW'(b); dest_reg = AW'(dest);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int n = 1; n <= lat + 3; n++) begin
      if (n > 1) @(negedge clk);
      if (done) begin seen = n; break; end
      check("busy_before_done", int'(busy), 1);
      if (poke && n == 2) begin
        start = 1'b1; alu_op = 3'($urandom_range(0, 7));
        operand_a = DW'($urandom); operand_b = DW'($urandom); dest_reg = AW'(~dest);
      end else if (n == 3) begin
        start = 1'b0;
      end
    end
    check("done_latency", seen, lat);
    check("result", int'(result), res);
    check("zero", int'(zero), (res == 0) ? 1 : 0);
    check("overflow", int'(overflow), ovf);
    check("illegal", int'(illegal), ill);
    check("reg_write", int'(reg_write), 1 - ill);
    if (ill == 0) begin
      check("write_register", int'(write_register), dest);
      check("write_data", int'(write_data), res);
    end
    start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("reg_write_one_cycle", int'(reg_write), 0);
    check("busy_after_wb", int'(busy), 0);
    check("result_held", int'(result), res);
    last_result = res;
  endtask

  initial begin
    int seen;
    reset = 1'b1; start = 1'b0; alu_op = '0; operand_a = '0; operand_b = '0; dest_reg = '0;
    @(negedge clk); @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_zero", int'(zero), 1);
    check("rst_reg_write", int'(reg_write), 0);
    check("rst_write_register", int'(write_register), 0);
    check("rst_state", int'(dbg_state), 0);
    reset = 1'b0;

    run_op(0, 7, 5, 1, 1'b0);
    check("add_7_5", last_result, 12);
    run_op(0, 10, 7, 0, 1'b0);
    check("add_10_7", last_result, 17);
    check("add_10_7_ovf", int'(overflow), 1);
    run_op(1, 5, 5, 1, 1'b0);
    check("sub_5_5_zero", int'(zero), 1);
    run_op(5, 7, 5, 1, 1'b0);
    check("mul_7_5", last_result, 3);
    run_op(4, 31, 1, 0, 1'b0);
    check("slt_m1_1", last_result, 1);
    run_op(6, 16, 4, 1, 1'b0);
    check("srl_16_4", last_result, 1);
    run_op(6, 31, 5, 1, 1'b0);
    run_op(6, 31, 7, 0, 1'b0);
    run_op(5, 7, 5, 0, 1'b1);
    check("mul_poked", last_result, 3);
    run_op(7, 9, 3, 1, 1'b0);

    // Reset during the third multiply cycle aborts with no writeback.
    @(negedge clk);
    start = 1'b1; alu_op = 3'd5; operand_a = 5'd9; operand_b = 5'd9; dest_reg = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_reg_write", int'(reg_write), 0);
    check("abort_result", int'(result), 0);
    seen = 0;
    for (int n = 0; n < DW + 4; n++) begin
      @(negedge clk);
      if (done || reg_write || busy) seen = 1;
    end
    check("abort_stays_idle", seen, 0);

    for (int i = 0; i < 40; i++)
      run_op($urandom_range(0, 7), $urandom_range(0, MOD - 1), $urandom_range(0, MOD - 1),
             $urandom_range(0, 1), ($urandom_range(0, 3) == 0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
